tlight_monitor: RTL and testbench
=================================

TLIGHT_MONITOR -- requirements
Module: tlight_monitor

Interface
REQ-001 Parameter MIN_DWELL, default 1: minimum cycles a lamp pattern must hold before a legal advance.
REQ-002 Parameter MAX_DWELL, default 16: maximum cycles a lamp pattern may hold before a timeout error.
REQ-003 Parameter CNT_W, default 8: width of the dwell and sequence counters; MAX_DWELL SHALL be < 2^CNT_W - 1.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 r  input  1  red lamp observed from the traffic-light controller.
REQ-007 a  input  1  amber lamp observed.
REQ-008 g  input  1  green lamp observed.
REQ-009 err_clr  input  1  clears sticky error state.
REQ-010 phase  output  3  decoded phase: 0 UNKNOWN, 1 RED, 2 RED_AMBER, 3 GREEN, 4 AMBER.
REQ-011 locked  output  1  monitor is tracking a legal sequence.
REQ-012 err  output  1  sticky error flag.
REQ-013 err_code  output  2  first error captured: 00 none, 01 SEQUENCE, 10 SHORT, 11 TIMEOUT.
REQ-014 dwell  output  CNT_W  cycles the current phase has held, inclusive of its first cycle.
REQ-015 seq_count  output  CNT_W  number of completed sequences (entries into RED while locked).

Function
REQ-016 Lamps SHALL be registered once (sample stage); the monitor SHALL act on the sampled value one edge later, so outputs reflect a lamp change 2 rising edges after it is applied.
REQ-017 Pattern decode {r,a,g}: 100 RED, 110 RED_AMBER, 001 GREEN, 010 AMBER; all other patterns (including 000) are illegal.
REQ-018 Legal successor order: RED -> RED_AMBER -> GREEN -> AMBER -> RED.
REQ-019 Two control states: UNLOCKED and LOCKED.
REQ-020 UNLOCKED: phase=0, dwell=0; the first legal sampled pattern SHALL enter LOCKED with phase=that pattern and dwell=1; an illegal pattern keeps UNLOCKED with no error.
REQ-021 LOCKED, sampled pattern equals current phase: dwell increments, saturating at 2^CNT_W-1.
REQ-022 LOCKED, dwell transitions from MAX_DWELL to MAX_DWELL+1: raise TIMEOUT error; remain LOCKED.
REQ-023 LOCKED, sampled pattern is the legal successor: if dwell < MIN_DWELL raise SHORT error; in all cases advance phase and set dwell=1.
REQ-024 Entering RED via a legal advance SHALL increment seq_count, wrapping 2^CNT_W-1 -> 0; locking directly into RED SHALL NOT increment it.
REQ-025 LOCKED, sampled pattern is illegal or a non-successor legal pattern: raise SEQUENCE error, go UNLOCKED (phase=0, dwell=0) on the same edge.
REQ-026 Raising an error sets err=1; err_code loads the new code only if err was 0 (first-error capture).
REQ-027 err_clr=1 clears err and err_code to 0 unless an error is raised on the same edge, in which case err=1 and err_code=the new code.
REQ-028 err_clr SHALL NOT affect phase, locked, dwell or seq_count.
REQ-029 At most one error code is raised per edge; the SEQUENCE, SHORT and TIMEOUT conditions are mutually exclusive by construction.
REQ-030 All outputs SHALL be driven from registers.

Reset
REQ-031 rst=1 at a rising edge SHALL set the sample register to 000, state UNLOCKED, phase=0, locked=0, err=0, err_code=00, dwell=0, seq_count=0.
REQ-032 rst SHALL take priority over err_clr and all lamp activity; a reset mid-sequence discards the phase, and relock follows REQ-020.

Verification
REQ-033 Defaults; after reset drive lamps 001,010,100,110,001 one per cycle -> locks GREEN, phase steps 3,4,1,2,3, seq_count=1, err=0.
REQ-034 Locked in GREEN, drive 100 -> SEQUENCE: err=1, err_code=01, locked=0, phase=0 two edges after the change.
REQ-035 MIN_DWELL=3; hold RED for 2 cycles then 110 -> err_code=10, phase=2, dwell=1, locked=1.
REQ-036 MAX_DWELL=4; hold GREEN for 6 cycles -> err_code=11 on the edge where dwell becomes 5; dwell then reaches 6; locked=1.
REQ-037 With err_code=10 latched, cause TIMEOUT -> err_code stays 10; then pulse err_clr coincident with a SEQUENCE error -> err=1, err_code=01.
REQ-038 CNT_W=2; run 4 full legal sequences -> seq_count goes 1,2,3,0; assert rst mid-AMBER -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/tlight_monitor.sv
// Traffic-light lamp sequence monitor: samples {r,a,g}, tracks the legal
// RED -> RED_AMBER -> GREEN -> AMBER cycle and latches the first error.
module tlight_monitor #(
  parameter int MIN_DWELL = 1,
  parameter int MAX_DWELL = 16,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r,
  input  logic             a,
  input  logic             g,
  input  logic             err_clr,
  output logic [2:0]       phase,
  output logic             locked,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] dwell,
  output logic [CNT_W-1:0] seq_count
);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    PH_UNK = 3'd0,
    PH_RED = 3'd1,
    PH_RA  = 3'd2,
    PH_GRN = 3'd3,
    PH_AMB = 3'd4
  } phase_e;

  localparam logic [1:0] E_NONE  = 2'b00;
  localparam logic [1:0] E_SEQ   = 2'b01;
  localparam logic [1:0] E_SHORT = 2'b10;
  localparam logic [1:0] E_TMO   = 2'b11;

  localparam logic [CNT_W-1:0] DW_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DW_SAT = '1;
  localparam logic [CNT_W-1:0] DW_MIN = CNT_W'(MIN_DWELL);
  localparam logic [CNT_W-1:0] DW_TMO = CNT_W'(MAX_DWELL);

  logic [2:0]       samp_q, samp_d;
  state_e           state_q, state_d;
  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0] seq_q, seq_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;

  phase_e     pat;
  phase_e     succ;
  logic [1:0] new_err;

  always_comb begin
    pat = PH_UNK;
    unique case (samp_q)
      3'b100:  pat = PH_RED;
      3'b110:  pat = PH_RA;
      3'b001:  pat = PH_GRN;
      3'b010:  pat = PH_AMB;
      default: pat = PH_UNK;
    endcase
  end

  always_comb begin
    succ = PH_UNK;
    unique case (phase_q)
      PH_RED:  succ = PH_RA;
      PH_RA:   succ = PH_GRN;
      PH_GRN:  succ = PH_AMB;
      PH_AMB:  succ = PH_RED;
      default: succ = PH_UNK;
    endcase
  end

  always_comb begin
    samp_d  = {r, a, g};
    state_d = state_q;
    phase_d = phase_q;
    dwell_d = dwell_q;
    seq_d   = seq_q;
    new_err = E_NONE;
    unique case (state_q)
      UNLOCKED: begin
        if (pat != PH_UNK) begin
          state_d = LOCKED;
          phase_d = pat;
          dwell_d = DW_ONE;
        end
      end
      LOCKED: begin
        if (pat == phase_q) begin
          if (dwell_q == DW_TMO) new_err = E_TMO;
          if (dwell_q != DW_SAT) dwell_d = dwell_q + DW_ONE;
        end else if (pat != PH_UNK && pat == succ) begin
          if (dwell_q < DW_MIN) new_err = E_SHORT;
          phase_d = pat;
          dwell_d = DW_ONE;
          if (pat == PH_RED) seq_d = seq_q + DW_ONE;
        end else begin
          new_err = E_SEQ;
          state_d = UNLOCKED;
          phase_d = PH_UNK;
          dwell_d = '0;
        end
      end
      default: state_d = UNLOCKED;
    endcase
  end

  // A new error beats err_clr; otherwise only the first code is kept.
  always_comb begin
    err_d  = err_q;
    code_d = code_q;
    if (new_err != E_NONE) begin
      err_d = 1'b1;
      if (!err_q || err_clr) code_d = new_err;
    end else if (err_clr) begin
      err_d  = 1'b0;
      code_d = E_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q  <= 3'b000;
      state_q <= UNLOCKED;
      phase_q <= PH_UNK;
      dwell_q <= '0;
      seq_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= E_NONE;
    end else begin
      samp_q  <= samp_d;
      state_q <= state_d;
      phase_q <= phase_d;
      dwell_q <= dwell_d;
      seq_q   <= seq_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign phase     = phase_q;
  assign locked    = state_q;
  assign err       = err_q;
  assign err_code  = code_q;
  assign dwell     = dwell_q;
  assign seq_count = seq_q;

endmodule

// File: tb/tb_tlight_monitor.sv
// Bench for tlight_monitor: three parameterisations share one lamp stream
// and are compared every cycle against a rule-level reference model.
module tb_tlight_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic r = 1'b0, a = 1'b0, g = 1'b0;
  logic err_clr = 1'b0;

  always #5 clk = ~clk;

  logic [2:0] ph0, ph1, ph2;
  logic       lk0, lk1, lk2;
  logic       er0, er1, er2;
  logic [1:0] ec0, ec1, ec2;
  logic [7:0] dw0, dw1, sc0, sc1;
  logic [1:0] dw2, sc2;

  tlight_monitor u0 (
    .clk(clk), .rst(rst), .r(r), .a(a), .g(g), .err_clr(err_clr),
    .phase(ph0), .locked(lk0), .err(er0), .err_code(ec0),
    .dwell(dw0), .seq_count(sc0)
  );

  tlight_monitor #(.MIN_DWELL(3), .MAX_DWELL(4)) u1 (
    .clk(clk), .rst(rst), .r(r), .a(a), .g(g), .err_clr(err_clr),
    .phase(ph1), .locked(lk1), .err(er1), .err_code(ec1),
    .dwell(dw1), .seq_count(sc1)
  );

  tlight_monitor #(.MAX_DWELL(2), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .r(r), .a(a), .g(g), .err_clr(err_clr),
    .phase(ph2), .locked(lk2), .err(er2), .err_code(ec2),
    .dwell(dw2), .seq_count(sc2)
  );

  int tests = 0;
  int fails = 0;

  int mn [3] = '{1, 3, 1};
  int mx [3] = '{16, 4, 2};
  int wd [3] = '{8, 8, 2};

  int m_samp [3];
  int m_lk [3], m_ph [3], m_dw [3], m_sc [3], m_e [3], m_ec [3];

  // phase index of each {r,a,g} value: RED=1 RED_AMBER=2 GREEN=3 AMBER=4
  int dec [8] = '{0, 3, 4, 0, 1, 0, 2, 0};
  logic [2:0] lamp_of [5];

  task automatic model(input logic [2:0] l, input bit c, input bit rs);
    for (int i = 0; i < 3; i++) begin
      int full;
      int pat;
      int ne;
      full = (1 << wd[i]) - 1;
      ne = 0;
      if (rs) begin
        m_samp[i] = 0;
        m_lk[i] = 0; m_ph[i] = 0; m_dw[i] = 0;
        m_sc[i] = 0; m_e[i] = 0; m_ec[i] = 0;
      end else begin
        pat = dec[m_samp[i]];
        if (m_lk[i] == 0) begin
          if (pat != 0) begin
            m_lk[i] = 1; m_ph[i] = pat; m_dw[i] = 1;
          end
        end else if (pat == m_ph[i]) begin
          if (m_dw[i] == mx[i]) ne = 3;
          if (m_dw[i] < full) m_dw[i]++;
        end else if (pat != 0 && pat == m_ph[i] % 4 + 1) begin
          if (m_dw[i] < mn[i]) ne = 2;
          if (pat == 1) m_sc[i] = (m_sc[i] + 1) % (full + 1);
          m_ph[i] = pat; m_dw[i] = 1;
        end else begin
          ne = 1;
          m_lk[i] = 0; m_ph[i] = 0; m_dw[i] = 0;
        end
        if (ne != 0) begin
          if (m_e[i] == 0 || c) m_ec[i] = ne;
          m_e[i] = 1;
        end else if (c) begin
          m_e[i] = 0; m_ec[i] = 0;
        end
        m_samp[i] = int'(l);
      end
    end
  endtask

  function automatic logic [22:0] pk(int i);
    return {3'(m_ph[i]), 1'(m_lk[i]), 1'(m_e[i]), 2'(m_ec[i]),
            8'(m_dw[i]), 8'(m_sc[i])};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [2:0] l, input bit c, input bit rs);
    {r, a, g} = l;
    err_clr = c;
    rst = rs;
    @(posedge clk);
    model(l, c, rs);
    #1;
    chk("u0", {9'd0, ph0, lk0, er0, ec0, dw0, sc0}, {9'd0, pk(0)});
    chk("u1", {9'd0, ph1, lk1, er1, ec1, dw1, sc1}, {9'd0, pk(1)});
    chk("u2", {9'd0, ph2, lk2, er2, ec2, 6'd0, dw2, 6'd0, sc2},
        {9'd0, pk(2)});
  endtask

  initial begin
    logic [2:0] l;
    int cur;
    bit c, rs;
    lamp_of = '{3'b000, 3'b100, 3'b110, 3'b001, 3'b010};

    step(3'b000, 0, 1);
    step(3'b000, 0, 1);
    chk("rst_u0", {9'd0, ph0, lk0, er0, ec0, dw0, sc0}, 32'd0);

    // legal run starting in GREEN
    step(3'b001, 0, 0);
    step(3'b010, 0, 0);
    step(3'b100, 0, 0);
    step(3'b110, 0, 0);
    step(3'b001, 0, 0);
    step(3'b001, 0, 0);
    chk("run_phase", ph0, 3);
    chk("run_seq", sc0, 1);
    chk("run_err", er0, 0);

    // GREEN -> RED is out of order
    step(3'b100, 0, 0);
    step(3'b100, 0, 0);
    chk("seq_err", {er0, ec0, lk0, ph0}, {1'b1, 2'b01, 1'b0, 3'd0});

    // timeout on u1 (MAX_DWELL=4)
    step(3'b000, 0, 1);
    for (int k = 0; k < 6; k++) step(3'b001, 0, 0);
    chk("tmo_code", {dw1, 6'd0, ec1}, {8'd5, 6'd0, 2'b11});
    step(3'b001, 0, 0);
    chk("tmo_hold", {dw1, 7'd0, lk1}, {8'd6, 7'd0, 1'b1});

    // short dwell on u1 (MIN_DWELL=3), then timeout, then clr+SEQUENCE
    step(3'b000, 0, 1);
    step(3'b100, 0, 0);
    step(3'b100, 0, 0);
    step(3'b110, 0, 0);
    step(3'b110, 0, 0);
    chk("short", {ec1, ph1, dw1, lk1}, {2'b10, 3'd2, 8'd1, 1'b1});
    step(3'b110, 0, 0);
    step(3'b110, 0, 0);
    for (int k = 0; k < 6; k++) step(3'b001, 0, 0);
    chk("first_kept", {dw1, er1, ec1}, {8'd5, 1'b1, 2'b10});
    step(3'b100, 0, 0);
    step(3'b100, 1, 0);
    chk("clr_vs_err", {er1, ec1, lk1}, {1'b1, 2'b01, 1'b0});

    // seq_count wrap on u2 (CNT_W=2), reset mid-AMBER
    step(3'b000, 0, 1);
    step(3'b100, 0, 0);
    for (int k = 0; k <= 4; k++) begin
      step(3'b110, 0, 0);
      if (k > 0) chk("wrap_seq", sc2, k % 4);
      step(3'b001, 0, 0);
      step(3'b010, 0, 0);
      step(k < 4 ? 3'b100 : 3'b010, 0, 0);
    end
    chk("amber", ph2, 4);
    step(3'b010, 1, 1);
    chk("rst_mid", {ph2, lk2, er2, ec2, dw2, sc2}, 32'd0);

    // randomized mostly-legal traffic
    cur = 1;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) cur = cur % 4 + 1;
      l = lamp_of[cur];
      if ($urandom_range(0, 19) == 0) l = 3'($urandom_range(0, 7));
      c = ($urandom_range(0, 9) == 0);
      rs = ($urandom_range(0, 99) == 0);
      step(l, c, rs);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
